// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the input-port FIFO.
// Contents:
//   IO_DATA_W     - width of a switch word (32)
//   IO_FIFO_DEPTH - default FIFO depth (4)
//   IO_DB_CYCLES  - default debounce stability window in cycles (16)
//   io_word_t     - one switch word
package io_pkg;
    localparam int IO_DATA_W     = 32;
    localparam int IO_FIFO_DEPTH = 4;
    localparam int IO_DB_CYCLES  = 16;
    typedef logic [IO_DATA_W-1:0] io_word_t;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: level filter that follows its input only after it has held a new value
// for DB_CYCLES consecutive cycles; any return to the current level restarts the count.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (level and counter cleared to 0)
//   i_d  - synchronized input level
//   o_q  - filtered level
module io_debounce
    import io_pkg::*;
#(
    parameter int DB_CYCLES = IO_DB_CYCLES
)(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b0;
            r_cnt <= '0;
        end else if (i_d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_q   <= i_d;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/io_in_port.sv
// io_in_port: captures the switch word on each filtered button press into a show-ahead FIFO
// read by the IO interface.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   sw         - raw switch word
//   btn        - raw asynchronous "data valid" button
//   rd_ack     - one-cycle pulse: IO interface consumed data_input
//   data_input - FIFO head word (0 when empty)
//   is_ready   - FIFO non-empty
//   overflow   - sticky: a capture was dropped because the FIFO was full
//   count      - FIFO occupancy
// Configuration: define IO_IN_DEBOUNCE_EN to insert the io_debounce filter after the
// synchronizer; otherwise the synchronizer output is used directly and DB_CYCLES is unused.
module io_in_port
    import io_pkg::*;
#(
    parameter int DEPTH     = IO_FIFO_DEPTH,
    parameter int DB_CYCLES = IO_DB_CYCLES
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IO_DATA_W-1:0]   sw,
    input  logic                   btn,
    input  logic                   rd_ack,
    output logic [IO_DATA_W-1:0]   data_input,
    output logic                   is_ready,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || DB_CYCLES < 1) begin : g_bad_param
        $error("io_in_port: DEPTH must be a power of two in 2..16 and DB_CYCLES >= 1");
    end

    io_word_t      r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [1:0]    r_sync, r_vld;
    logic          r_armed, r_prev, r_ovf;
    logic          w_filt, w_push, w_pop, w_full, w_wr;

`ifdef IO_IN_DEBOUNCE_EN
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk (clk),
        .rst (rst),
        .i_d (r_sync[1]),
        .o_q (w_filt)
    );
`else
    assign w_filt = r_sync[1];
`endif

    // Reset clears the synchronizer, so a button held through reset would look like a fresh
    // press once the pipeline refills. Edges are only accepted after a genuine post-reset
    // low has been seen (r_vld marks when the synchronizer holds post-reset samples).
    assign w_push = r_armed && w_filt && !r_prev;
    assign w_full = r_count == (AW+1)'(DEPTH);
    assign w_pop  = rd_ack && r_count != '0;
    // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed || (r_vld[1] && !r_sync[1]);
            r_prev  <= w_filt;
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wp] <= sw;
    end

    assign data_input = (r_count != '0) ? r_mem[r_rp] : '0;
    assign is_ready   = r_count != '0;
    assign overflow   = r_ovf;
    assign count      = r_count;
endmodule

// File: tb/tb_io_in_port.sv
// tb_io_in_port: randomized self-checking bench for io_in_port against a queue-based model.
module tb_io_in_port;
    localparam int DEPTH = 4;
`ifdef IO_IN_DEBOUNCE_EN
    localparam int DBX = 16;
`else
    localparam int DBX = 0;
`endif
    // Edges from the first edge sampling btn high up to and including the push edge.
    localparam int PUSH_EDGES = 3 + DBX;

    logic        clk = 0, rst = 0, btn = 0, rd_ack = 0;
    logic [31:0] sw = 0, data_input;
    logic        is_ready, overflow;
    logic [2:0]  count;
    int          tests = 0, fails = 0;
    logic [31:0] q[$];
    bit          ovf_m = 0;

    io_in_port #(.DEPTH(DEPTH), .DB_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .rd_ack     (rd_ack),
        .data_input (data_input),
        .is_ready   (is_ready),
        .overflow   (overflow),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model(bit push, bit ack, logic [31:0] w);
        bit full = q.size() == DEPTH;
        bit popped = ack && q.size() > 0;
        if (popped) void'(q.pop_front());
        if (push && (!full || popped)) q.push_back(w);
        else if (push) ovf_m = 1;
    endfunction

    task automatic press(logic [31:0] w, bit ack);
        sw = w;
        btn = 1;
        step(PUSH_EDGES - 1);
        rd_ack = ack;
        step();
        rd_ack = 0;
        model(1, ack, w);
        btn = 0;
        step(3 + DBX);
    endtask

    task automatic pop_one;
        rd_ack = 1;
        step();
        rd_ack = 0;
        model(0, 1, 0);
    endtask

    task automatic test_reset;
        rst = 1;
        step(2);
        rst = 0;
        q.delete();
        ovf_m = 0;
        tests += 4;
        if (is_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", is_ready); end
        if (data_input !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", data_input); end
        if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        step(4);
    endtask

    task automatic test_single;
        sw = 32'h0000_00A5;
        btn = 1;
        step(PUSH_EDGES - 1);
        tests++;
        if (is_ready !== 1'b0) begin fails++; $display("FAIL single_early_ready got %b exp 0", is_ready); end
        step();
        model(1, 0, 32'h0000_00A5);
        tests += 3;
        if (is_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b exp 1", is_ready); end
        if (data_input !== 32'h0000_00A5) begin fails++; $display("FAIL single_data got %h exp 000000a5", data_input); end
        if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
        btn = 0;
        step(3 + DBX);
        pop_one();
        tests += 3;
        if (is_ready !== 1'b0) begin fails++; $display("FAIL single_pop_ready got %b exp 0", is_ready); end
        if (count !== 3'd0) begin fails++; $display("FAIL single_pop_count got %0d exp 0", count); end
        if (data_input !== 32'h0) begin fails++; $display("FAIL single_pop_data got %h exp 0", data_input); end
    endtask

    task automatic test_overflow;
        test_reset();
        for (int i = 1; i <= 5; i++) press(32'h11 * i, 0);
        tests += 2;
        if (count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", count); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (data_input !== 32'h11 * i) begin fails++; $display("FAIL ovf_order%0d got %h exp %h", i, data_input, 32'h11 * i); end
            pop_one();
        end
        tests += 2;
        if (count !== 3'd0) begin fails++; $display("FAIL ovf_drained got %0d exp 0", count); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] words [5];
        test_reset();
        foreach (words[i]) words[i] = $urandom;
        for (int i = 0; i < 4; i++) press(words[i], 0);
        press(words[4], 1);
        tests += 3;
        if (count !== 3'd4) begin fails++; $display("FAIL full_pp_count got %0d exp 4", count); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL full_pp_ovf got %b exp 0", overflow); end
        if (data_input !== words[1]) begin fails++; $display("FAIL full_pp_head got %h exp %h", data_input, words[1]); end
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (data_input !== words[i]) begin fails++; $display("FAIL full_pp_order%0d got %h exp %h", i, data_input, words[i]); end
            pop_one();
        end
    endtask

    task automatic test_empty_push_pop;
        logic [31:0] w;
        test_reset();
        w = $urandom;
        press(w, 1);
        tests += 2;
        if (count !== 3'd1) begin fails++; $display("FAIL empty_pp_count got %0d exp 1", count); end
        if (data_input !== w) begin fails++; $display("FAIL empty_pp_head got %h exp %h", data_input, w); end
        pop_one();
        pop_one();
        tests += 3;
        if (count !== 3'd0) begin fails++; $display("FAIL empty_ack_count got %0d exp 0", count); end
        if (is_ready !== 1'b0) begin fails++; $display("FAIL empty_ack_ready got %b exp 0", is_ready); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL empty_ack_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_random;
        logic [31:0] exp_d;
        test_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) pop_one();
            else press($urandom, 1'($urandom_range(0, 1)));
            exp_d = q.size() ? q[0] : 32'h0;
            tests += 4;
            if (count !== q.size()) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", i, count, q.size()); end
            if (is_ready !== (q.size() != 0)) begin fails++; $display("FAIL rand%0d_ready got %b exp %b", i, is_ready, q.size() != 0); end
            if (data_input !== exp_d) begin fails++; $display("FAIL rand%0d_data got %h exp %h", i, data_input, exp_d); end
            if (overflow !== ovf_m) begin fails++; $display("FAIL rand%0d_ovf got %b exp %b", i, overflow, ovf_m); end
        end
    endtask

    task automatic test_reset_held;
        logic [31:0] w;
        test_reset();
        for (int i = 0; i < 4; i++) press($urandom, 0);
        press($urandom, 0);
        pop_one();
        pop_one();
        tests++;
        if (count !== 3'd2) begin fails++; $display("FAIL held_pre_count got %0d exp 2", count); end
        press($urandom, 0);
        btn = 1;
        rst = 1;
        step();
        rst = 0;
        q.delete();
        ovf_m = 0;
        tests += 2;
        if (count !== 3'd0) begin fails++; $display("FAIL held_rst_count got %0d exp 0", count); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL held_rst_ovf got %b exp 0", overflow); end
        step(10 + 2 * DBX);
        tests++;
        if (count !== 3'd0) begin fails++; $display("FAIL held_nopush got %0d exp 0", count); end
        btn = 0;
        step(3 + DBX);
        w = $urandom;
        press(w, 0);
        tests += 2;
        if (count !== 3'd1) begin fails++; $display("FAIL held_repress_count got %0d exp 1", count); end
        if (data_input !== w) begin fails++; $display("FAIL held_repress_data got %h exp %h", data_input, w); end
    endtask

`ifdef IO_IN_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] w;
        test_reset();
        w = $urandom;
        sw = w;
        btn = 1;
        step(3);
        btn = 0;
        step(3);
        btn = 1;
        step(PUSH_EDGES - 1);
        tests++;
        if (is_ready !== 1'b0) begin fails++; $display("FAIL db_early_ready got %b exp 0", is_ready); end
        step();
        tests++;
        if (is_ready !== 1'b1) begin fails++; $display("FAIL db_ready got %b exp 1", is_ready); end
        step(20 - PUSH_EDGES);
        btn = 0;
        step(3 + DBX);
        tests += 2;
        if (count !== 3'd1) begin fails++; $display("FAIL db_count got %0d exp 1", count); end
        if (data_input !== w) begin fails++; $display("FAIL db_data got %h exp %h", data_input, w); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_random();
        test_reset_held();
`ifdef IO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
